// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads one big-endian word from the instruction ROM into ir.
// Optional macro FETCH_ALIGN_CHECK_EN faults misaligned fetch addresses.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ROM_BYTES  = 100,
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        fetch_req,
  input  logic        pc_wre,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_target,
  input  logic [31:0] reg_target,
  input  logic [31:0] rom_data,
  output logic        ins_mem_rw,
  output logic [31:0] rom_addr,
  output logic [31:0] ir,
  output logic        ins_valid,
  output logic        busy,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, REQ, HALT, FAULT} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(FETCH_WAIT);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        ins_valid_reg, ins_valid_next;
  logic        halted_reg, halted_next;
  logic        fault_reg, fault_next;

  logic [31:0] pc_target;
  logic [32:0] fetch_end;
  logic        range_bad;
  logic        align_bad;

  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    pc_target = pc_plus4;
    case (pc_src)
      2'b00:   pc_target = pc_plus4;
      2'b01:   pc_target = pc_plus4 + (imm_ext << 2);
      2'b10:   pc_target = {pc_plus4[31:28], jump_target, 2'b00};
      default: pc_target = reg_target;
    endcase
  end

  // Widened so a PC near 2^32 cannot wrap past the range check.
  assign fetch_end = {1'b0, pc_reg} + 33'd3;
  assign range_bad = (fetch_end >= 33'(ROM_BYTES));

`ifdef FETCH_ALIGN_CHECK_EN
  assign align_bad = (pc_reg[1:0] != 2'b00);
`else
  assign align_bad = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ir_next        = ir_reg;
    cnt_next       = cnt_reg;
    ins_valid_next = 1'b0;
    halted_next    = halted_reg;
    fault_next     = fault_reg;
    case (state_reg)
      IDLE: begin
        if (pc_wre) begin
          pc_next = pc_target;
        end
        // The check looks at the pre-update pc even when pc_wre acts at the same edge.
        if (fetch_req) begin
          if (range_bad || align_bad) begin
            state_next = FAULT;
            fault_next = 1'b1;
          end else begin
            state_next = REQ;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      REQ: begin
        if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
        end else begin
          ir_next        = rom_data;
          ins_valid_next = 1'b1;
          if (rom_data[31:26] == 6'b111111) begin
            state_next  = HALT;
            halted_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = state_reg;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      ir_reg        <= 32'h0;
      cnt_reg       <= 4'd0;
      ins_valid_reg <= 1'b0;
      halted_reg    <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      ir_reg        <= ir_next;
      cnt_reg       <= cnt_next;
      ins_valid_reg <= ins_valid_next;
      halted_reg    <= halted_next;
      fault_reg     <= fault_next;
    end
  end

  assign ins_mem_rw = (state_reg == REQ);
  assign busy       = (state_reg != IDLE);
  assign rom_addr   = pc_reg;
  assign pc         = pc_reg;
  assign ir         = ir_reg;
  assign ins_valid  = ins_valid_reg;
  assign halted     = halted_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: one instance with FETCH_WAIT=0, one with FETCH_WAIT=3, shared ROM model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst0, rst3;
  logic        fr0, fr3, wre0, wre3;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext;
  logic [25:0] jump_target;
  logic [31:0] reg_target;
  logic [31:0] rom_data0, rom_data3;

  logic        rw0, v0, busy0, h0, f0;
  logic [31:0] addr0, ir0, pc0, pp0;
  logic        rw3, v3, busy3, h3, f3;
  logic [31:0] addr3, ir3, pc3, pp3;

  logic [7:0] rom [0:99];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    logic [32:0] e;
    e = {1'b0, a} + 33'd3;
    if (e < 33'd100) return {rom[a], rom[a+1], rom[a+2], rom[a+3]};
    return 32'h0;
  endfunction

  always_comb rom_data0 = rd(addr0);
  always_comb rom_data3 = rd(addr3);

  instr_fetch_unit #(.RESET_PC(32'h0), .ROM_BYTES(100), .FETCH_WAIT(0)) dut0 (
    .CLK(clk), .Reset(rst0), .fetch_req(fr0), .pc_wre(wre0), .pc_src(pc_src),
    .imm_ext(imm_ext), .jump_target(jump_target), .reg_target(reg_target),
    .rom_data(rom_data0), .ins_mem_rw(rw0), .rom_addr(addr0), .ir(ir0),
    .ins_valid(v0), .busy(busy0), .pc(pc0), .pc_plus4(pp0), .halted(h0), .fault(f0));

  instr_fetch_unit #(.RESET_PC(32'h0), .ROM_BYTES(100), .FETCH_WAIT(3)) dut3 (
    .CLK(clk), .Reset(rst3), .fetch_req(fr3), .pc_wre(wre3), .pc_src(pc_src),
    .imm_ext(imm_ext), .jump_target(jump_target), .reg_target(reg_target),
    .rom_data(rom_data3), .ins_mem_rw(rw3), .rom_addr(addr3), .ir(ir3),
    .ins_valid(v3), .busy(busy3), .pc(pc3), .pc_plus4(pp3), .halted(h3), .fault(f3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic setpc(input int sel, input logic [31:0] v);
    pc_src     = 2'b11;
    reg_target = v;
    if (sel == 0) wre0 = 1'b1; else wre3 = 1'b1;
    tick();
    wre0 = 1'b0;
    wre3 = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [25:0] jt;
    logic [31:0] rt;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];
  int   rwcnt, bcnt, vcyc;
  logic seen;

  initial begin
    for (int i = 0; i < 100; i++) rom[i] = 8'(i * 7 + 3);
    rom[0] = 8'h02; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h01;
    rom[8] = 8'hFC; rom[9] = 8'h00; rom[10] = 8'h00; rom[11] = 8'h00;
    rom[96] = 8'h12; rom[97] = 8'h34; rom[98] = 8'h56; rom[99] = 8'h78;

    // Sequential next-PC vectors, each applied from the previous row's PC (starting at 0).
    vt[0] = '{2'b01, 32'hFFFF_FFFF, 26'h0,         32'h0,         32'h0000_0000};
    vt[1] = '{2'b10, 32'h0,         26'h000_0005,  32'h0,         32'h0000_0014};
    vt[2] = '{2'b11, 32'h0,         26'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vt[3] = '{2'b00, 32'h0,         26'h0,         32'h0,         32'h0000_0000};
    vt[4] = '{2'b01, 32'h0000_0002, 26'h0,         32'h0,         32'h0000_000C};
    vt[5] = '{2'b10, 32'h0,         26'h3FF_FFFF,  32'h0,         32'h0FFF_FFFC};
    vt[6] = '{2'b00, 32'h0,         26'h0,         32'h0,         32'h1000_0000};
    vt[7] = '{2'b10, 32'h0,         26'h000_0001,  32'h0,         32'h1000_0004};
    vt[8] = '{2'b01, 32'hFFFF_FFFE, 26'h0,         32'h0,         32'h1000_0000};
    vt[9] = '{2'b11, 32'h0,         26'h0,         32'h0000_0060, 32'h0000_0060};

    rst0 = 1'b1; rst3 = 1'b1;
    fr0 = 1'b0; fr3 = 1'b0; wre0 = 1'b0; wre3 = 1'b0;
    pc_src = 2'b00; imm_ext = 32'h0; jump_target = 26'h0; reg_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc0", pc0, 32'h0);
    chk("rst_ir0", ir0, 32'h0);
    chk("rst_flags0", {28'h0, v0, rw0, h0, f0}, 32'h0);
    chk("rst_busy3", {31'h0, busy3}, 32'h0);
    rst0 = 1'b0; rst3 = 1'b0;
    tick();
    chk("idle_busy0", {31'h0, busy0}, 32'h0);
    chk("idle_pc_plus4", pp0, 32'h4);

    // FETCH_WAIT=0 fetch of word 0.
    fr0 = 1'b1;
    tick();
    fr0 = 1'b0;
    chk("w0_req_rw", {30'h0, rw0, v0}, 32'h2);
    chk("w0_req_busy", {31'h0, busy0}, 32'h1);
    tick();
    chk("w0_cap_rw_valid", {30'h0, rw0, v0}, 32'h1);
    chk("w0_cap_ir", ir0, 32'h0200_0001);
    chk("w0_cap_pc", pc0, 32'h0);
    tick();
    chk("w0_valid_drop", {31'h0, v0}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      pc_src = vt[i].src; imm_ext = vt[i].imm; jump_target = vt[i].jt; reg_target = vt[i].rt;
      wre0 = 1'b1;
      tick();
      wre0 = 1'b0;
      chk($sformatf("pc_vec%0d", i), pc0, vt[i].exp);
      chk($sformatf("pc_plus4_vec%0d", i), pp0, vt[i].exp + 32'd4);
    end

    // Last in-range word (bytes 96..99).
    fr0 = 1'b1;
    tick();
    fr0 = 1'b0;
    tick();
    chk("top_word_valid", {30'h0, v0, f0}, 32'h2);
    chk("top_word_ir", ir0, 32'h1234_5678);

    // Halt instruction at pc=8.
    setpc(0, 32'h8);
    fr0 = 1'b1;
    tick();
    fr0 = 1'b0;
    tick();
    chk("halt_valid", {31'h0, v0}, 32'h1);
    chk("halt_ir", ir0, 32'hFC00_0000);
    chk("halt_flag_busy", {30'h0, h0, busy0}, 32'h3);
    fr0 = 1'b1; wre0 = 1'b1; pc_src = 2'b11; reg_target = 32'h40;
    tick();
    tick();
    fr0 = 1'b0; wre0 = 1'b0;
    chk("halt_pc_hold", pc0, 32'h8);
    chk("halt_ignore", {28'h0, v0, rw0, h0, busy0}, 32'h3);

    // Range fault at pc=100.
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    tick();
    chk("rst_clears_halt", {31'h0, h0}, 32'h0);
    setpc(0, 32'd100);
    fr0 = 1'b1;
    tick();
    fr0 = 1'b0;
    chk("fault_flags", {29'h0, f0, busy0, rw0}, 32'h6);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      fr0 = (k == 2); wre0 = (k == 2);
      tick();
      if (v0 || rw0) seen = 1'b1;
    end
    fr0 = 1'b0; wre0 = 1'b0;
    chk("fault_no_valid", {31'h0, seen}, 32'h0);
    chk("fault_pc_hold", pc0, 32'd100);
    chk("fault_ir_hold", ir0, 32'h0);
    chk("fault_sticky", {31'h0, f0}, 32'h1);

    // FETCH_WAIT=3: count enable/busy cycles, with dropped mid-fetch requests.
    rwcnt = 0; bcnt = 0; vcyc = -1;
    fr3 = 1'b1;
    tick();
    fr3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rw3) rwcnt++;
      if (busy3) bcnt++;
      if (v3 && vcyc < 0) vcyc = k;
      if (k == 1) begin fr3 = 1'b1; wre3 = 1'b1; pc_src = 2'b11; reg_target = 32'h40; end
      if (k == 2) begin fr3 = 1'b0; wre3 = 1'b0; end
      tick();
    end
    chk("w3_rw_cycles", 32'(rwcnt), 32'd4);
    chk("w3_busy_cycles", 32'(bcnt), 32'd4);
    chk("w3_valid_cycle", 32'(vcyc), 32'd4);
    chk("w3_ir", ir3, 32'h0200_0001);
    chk("w3_pc_unchanged", pc3, 32'h0);

    // Reset asserted mid-fetch.
    setpc(3, 32'h60);
    fr3 = 1'b1;
    tick();
    fr3 = 1'b0;
    tick();
    chk("abort_in_req", {31'h0, rw3}, 32'h1);
    rst3 = 1'b1;
    #1;
    chk("abort_idle", {30'h0, busy3, rw3}, 32'h0);
    chk("abort_pc", pc3, 32'h0);
    chk("abort_ir", ir3, 32'h0);
    tick();
    rst3 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (v3) seen = 1'b1;
    end
    chk("abort_no_valid", {31'h0, seen}, 32'h0);

    // Misaligned pc=2.
    setpc(3, 32'h2);
    fr3 = 1'b1;
    tick();
    fr3 = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_fault", {29'h0, f3, busy3, rw3}, 32'h6);
`else
    repeat (4) tick();
    chk("misaligned_valid", {30'h0, v3, f3}, 32'h2);
    chk("misaligned_ir", ir3, 32'h0001_1F26);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
